hostflowctl: RTL and testbench

- Sits directly downstream of the Ethernet MAC receive AXI-Stream in the RVVI trace path.
- Parses host "slowme" control frames and latches the host FIFO fill amount carried in each one.
- Converts the fill amount into a HostStall throttle pattern: off, duty-cycled, or continuous.
- The parent ORs HostStall with RVVIStall to form ExternalStall back to the core.

---
 rtl/flowctl_pkg.sv | 42 ++++
 rtl/flowframeparse.sv | 76 +++++++
 rtl/hostflowctl.sv | 102 ++++++++++
 tb/tb_hostflowctl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flowctl_pkg.sv
// Shared types and constants for the host flow-control block.
// Holds the slowme header words, mode and parser enums, the RX beat
// payload struct and the fill-to-mode classifier.
package flowctl_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned HDR_WORDS = 5;
  localparam int unsigned IDX_W     = 3;

  localparam logic [15:0]       ETHERTYPE = 16'h005C;
  localparam logic [STRB_W-1:0] STRB_FULL = 4'hF;

  // Header words w0..w4; index 0 is the first beat of the frame.
  localparam logic [HDR_WORDS-1:0][DATA_W-1:0] HDR_WORD = {
    32'h656D_776F,
    {16'h6C73, ETHERTYPE},
    32'h8f54_0000,
    32'h1654_4502,
    32'h1111_6843
  };

  typedef enum logic [1:0] {OFF = 2'd0, THROTTLE = 2'd1, HOLD = 2'd2} mode_e;
  typedef enum logic [1:0] {HDR = 2'd0, FILL = 2'd1, DRAIN = 2'd2} parse_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic              valid;
  } axis_beat_t;

  // Classify a committed fill amount against the water marks.
  function automatic mode_e fill_mode(input logic [DATA_W-1:0] fill,
                                      input logic [DATA_W-1:0] hi,
                                      input logic [DATA_W-1:0] lo);
    if (fill >= hi)     return HOLD;
    else if (fill > lo) return THROTTLE;
    else                return OFF;
  endfunction

endpackage

// File: rtl/flowframeparse.sv
// Slowme frame parser.
// Ports: clk, reset (sync, active-high), beat (RX AXI-Stream beat),
//        commit_c (fill word accepted this cycle), fill_c (fill value),
//        drop_c (header mismatch, truncation or bad fill strobe this cycle).
module flowframeparse
  import flowctl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  axis_beat_t        beat,
  output logic              commit_c,
  output logic [DATA_W-1:0] fill_c,
  output logic              drop_c
);

  parse_state_e     state, state_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic             strb_ok_c;
  logic             word_ok_c;

  assign strb_ok_c = (beat.strb == STRB_FULL);
  assign word_ok_c = strb_ok_c && (beat.data == HDR_WORD[word_idx]);
  assign fill_c    = beat.data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      word_idx <= '0;
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
    end
  end

  // Next state and strobes; non-valid cycles leave everything untouched.
  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    commit_c     = 1'b0;
    drop_c       = 1'b0;
    if (beat.valid) begin
      unique case (state)
        HDR: begin
          if (!word_ok_c) begin
            drop_c       = 1'b1;
            word_idx_nxt = '0;
            state_nxt    = beat.last ? HDR : DRAIN;
          end else if (beat.last) begin
            // Frame ended inside the header.
            drop_c       = 1'b1;
            word_idx_nxt = '0;
          end else if (word_idx == IDX_W'(HDR_WORDS - 1)) begin
            word_idx_nxt = '0;
            state_nxt    = FILL;
          end else begin
            word_idx_nxt = word_idx + IDX_W'(1);
          end
        end
        FILL: begin
          commit_c  = strb_ok_c;
          drop_c    = !strb_ok_c;
          state_nxt = beat.last ? HDR : DRAIN;
        end
        DRAIN: begin
          if (beat.last) state_nxt = HDR;
        end
        default: begin
          state_nxt    = HDR;
          word_idx_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hostflowctl.sv
// Host flow control: turns the fill amount from host slowme frames into a
// HostStall throttle pattern (off, duty-cycled, continuous) with a timeout.
// Ports: clk, reset (sync, active-high), RvviAxiR* (MAC RX stream),
//        RVVIStall (freezes timeout), HostStall, HostFiFoFillAmt,
//        FrameAccepted, FrameDropped.
module hostflowctl
  import flowctl_pkg::*;
#(
  parameter logic [31:0] HIGH_WATER     = 32'd768,
  parameter logic [31:0] LOW_WATER      = 32'd256,
  parameter logic [31:0] PERIOD         = 32'd64,
  parameter int unsigned THROTTLE_SHIFT = 4,
  parameter logic [31:0] TIMEOUT        = 32'd1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] RvviAxiRdata,
  input  logic [STRB_W-1:0] RvviAxiRstrb,
  input  logic              RvviAxiRlast,
  input  logic              RvviAxiRvalid,
  input  logic              RVVIStall,
  output logic              HostStall,
  output logic [DATA_W-1:0] HostFiFoFillAmt,
  output logic              FrameAccepted,
  output logic              FrameDropped
);

  localparam logic [31:0] PERIOD_LAST  = PERIOD - 32'd1;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;

  axis_beat_t        rx_beat;
  logic              commit_c;
  logic              drop_c;
  logic [DATA_W-1:0] fill_c;
  logic [31:0]       shifted_c;
  logic [31:0]       len_new_c;
  mode_e             mode_new_c;

  mode_e       mode;
  logic [31:0] stall_len;
  logic [31:0] period_cnt;
  logic [31:0] timeout_cnt;

  assign rx_beat = {RvviAxiRdata, RvviAxiRstrb, RvviAxiRlast, RvviAxiRvalid};

  flowframeparse u_parse (
    .clk      (clk),
    .reset    (reset),
    .beat     (rx_beat),
    .commit_c (commit_c),
    .fill_c   (fill_c),
    .drop_c   (drop_c)
  );

  // Mode and duty length implied by the fill word on the stream.
  always_comb begin
    shifted_c  = fill_c >> THROTTLE_SHIFT;
    len_new_c  = (shifted_c > PERIOD_LAST) ? PERIOD_LAST : shifted_c;
    mode_new_c = fill_mode(fill_c, HIGH_WATER, LOW_WATER);
  end

  // Stall decode from registered state only, so a commit shows next cycle.
  assign HostStall = (mode == HOLD) | ((mode == THROTTLE) & (period_cnt < stall_len));

  // Commit, period and timeout tracking; a commit overrides an expiring timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode            <= OFF;
      stall_len       <= '0;
      period_cnt      <= '0;
      timeout_cnt     <= '0;
      HostFiFoFillAmt <= '0;
      FrameAccepted   <= 1'b0;
      FrameDropped    <= 1'b0;
    end else begin
      FrameAccepted <= commit_c;
      FrameDropped  <= drop_c;
      if (commit_c) begin
        HostFiFoFillAmt <= fill_c;
        mode            <= mode_new_c;
        stall_len       <= len_new_c;
        period_cnt      <= '0;
        timeout_cnt     <= '0;
      end else if (mode != OFF) begin
        period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 32'd1;
        if (!RVVIStall) begin
          if (timeout_cnt == TIMEOUT_LAST) begin
            mode        <= OFF;
            timeout_cnt <= '0;
            period_cnt  <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
          end
        end
      end else begin
        period_cnt  <= '0;
        timeout_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hostflowctl.sv
module tb_hostflowctl;

  localparam int PER = 64;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rdata;
  logic [3:0]  rstrb;
  logic        rlast, rvalid, rstall;
  logic        HostStall;
  logic [31:0] HostFiFoFillAmt;
  logic        FrameAccepted, FrameDropped;

  always #5 clk = ~clk;

  hostflowctl #(.TIMEOUT(32'd50)) dut (
    .clk             (clk),
    .reset           (reset),
    .RvviAxiRdata    (rdata),
    .RvviAxiRstrb    (rstrb),
    .RvviAxiRlast    (rlast),
    .RvviAxiRvalid   (rvalid),
    .RVVIStall       (rstall),
    .HostStall       (HostStall),
    .HostFiFoFillAmt (HostFiFoFillAmt),
    .FrameAccepted   (FrameAccepted),
    .FrameDropped    (FrameDropped)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position within the current frame plus time since commit.
  int          m_idx, m_mode, m_len, m_k, m_unst;
  bit          m_done;
  logic [31:0] m_fill;
  int          st_cfg;  // 0: RVVIStall low, 1: high, 2: random
  bit          last_stall;
  int          acc_seen, drop_seen;

  function automatic logic [31:0] hdr(input int i);
    case (i)
      0: return 32'h1111_6843;
      1: return 32'h1654_4502;
      2: return 32'h8f54_0000;
      3: return 32'h6C73_005C;
      4: return 32'h656D_776F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit cur_st();
    if (st_cfg == 0) return 1'b0;
    if (st_cfg == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the given beat; model predicts, DUT is sampled 1 after the edge.
  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] s, input bit l);
    bit acc, drp, st, exp_stall;
    acc = 1'b0;
    drp = 1'b0;
    st  = cur_st();
    rvalid = v; rdata = d; rstrb = s; rlast = l; rstall = st;
    if (v) begin
      if (!m_done) begin
        if (m_idx < 5) begin
          if (d !== hdr(m_idx) || s !== 4'hF) begin drp = 1'b1; m_done = 1'b1; end
          else if (l) drp = 1'b1;
        end else begin
          if (s !== 4'hF) drp = 1'b1; else acc = 1'b1;
          m_done = 1'b1;
        end
      end
      m_idx++;
      if (l) begin m_idx = 0; m_done = 1'b0; end
    end
    if (acc) begin
      m_fill = d;
      m_k = 0;
      m_unst = 0;
      if (d >= 768) m_mode = 2;
      else if (d > 256) begin
        m_mode = 1;
        m_len = int'(d / 16);
        if (m_len > PER - 1) m_len = PER - 1;
      end else m_mode = 0;
    end else if (m_mode != 0) begin
      m_k++;
      if (!st) m_unst++;
      if (m_unst >= TMO) m_mode = 0;
    end
    exp_stall = (m_mode == 2) || (m_mode == 1 && (m_k % PER) < m_len);
    @(posedge clk); #1;
    check("accepted", 32'(FrameAccepted), 32'(acc));
    check("dropped", 32'(FrameDropped), 32'(drp));
    check("fill_amt", HostFiFoFillAmt, m_fill);
    check("host_stall", 32'(HostStall), 32'(exp_stall));
    last_stall = HostStall;
    acc_seen  += int'(FrameAccepted);
    drop_seen += int'(FrameDropped);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 4'($urandom), 1'($urandom));
  endtask

  task automatic do_reset(input bit v, input logic [31:0] d);
    reset = 1'b1;
    rvalid = v; rdata = d; rstrb = 4'hF; rlast = 1'b0; rstall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_idx = 0; m_done = 1'b0; m_mode = 0; m_len = 0; m_k = 0; m_unst = 0; m_fill = '0;
    check("rst_accepted", 32'(FrameAccepted), 32'd0);
    check("rst_dropped", 32'(FrameDropped), 32'd0);
    check("rst_fill", HostFiFoFillAmt, 32'd0);
    check("rst_stall", 32'(HostStall), 32'd0);
  endtask

  // Frame of nbeats (Rlast on the final one); bad_idx flips bit 0, bad_strb uses 4'h7.
  task automatic frame(input logic [31:0] fill, input int bad_idx, input int bad_strb,
                       input int nbeats, input bit gaps);
    logic [31:0] w;
    logic [3:0]  s;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      w = (i < 5) ? hdr(i) : ((i == 5) ? fill : $urandom);
      if (i == bad_idx) w = w ^ 32'h1;
      s = (i == bad_strb) ? 4'h7 : 4'hF;
      step(1'b1, w, s, i == nbeats - 1);
    end
  endtask

  typedef struct {
    int          bad_idx;
    int          bad_strb;
    logic [31:0] fill;
    int          nbeats;
    int          exp_acc;
    int          exp_drop;
    logic [31:0] exp_amt;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   a0, d0, highs, win0, win1;
    bit   samp[0:127];
    logic [31:0] f;

    vecs = '{
      '{-1, -1, 32'd300,        6, 1, 0, 32'd300},
      '{ 2, -1, 32'd500,        6, 0, 1, 32'd300},
      '{-1,  5, 32'd900,        6, 0, 1, 32'd300},
      '{-1, -1, 32'd800,        6, 1, 0, 32'd800},
      '{-1, -1, 32'd100,        6, 1, 0, 32'd100},
      '{-1, -1, 32'd256,        6, 1, 0, 32'd256},
      '{-1, -1, 32'd768,        6, 1, 0, 32'd768},
      '{-1, -1, 32'd257,        6, 1, 0, 32'd257},
      '{-1, -1, 32'd999,        3, 0, 1, 32'd257},
      '{-1, -1, 32'd999,        5, 0, 1, 32'd257},
      '{ 0, -1, 32'd999,        6, 0, 1, 32'd257},
      '{-1, -1, 32'hFFFF_FFFF,  6, 1, 0, 32'hFFFF_FFFF},
      '{-1,  4, 32'd5,          7, 0, 1, 32'hFFFF_FFFF}
    };

    reset = 1'b1; rvalid = 1'b0; rdata = '0; rstrb = '0; rlast = 1'b0; rstall = 1'b0;
    st_cfg = 1; acc_seen = 0; drop_seen = 0;
    @(posedge clk); #1;
    do_reset(1'b0, 32'h0);

    // Table of single frames with per-frame pulse counts and resulting fill.
    foreach (vecs[i]) begin
      a0 = acc_seen; d0 = drop_seen;
      frame(vecs[i].fill, vecs[i].bad_idx, vecs[i].bad_strb, vecs[i].nbeats, 1'b1);
      idle(2);
      check($sformatf("tbl%0d_acc", i), 32'(acc_seen - a0), 32'(vecs[i].exp_acc));
      check($sformatf("tbl%0d_drop", i), 32'(drop_seen - d0), 32'(vecs[i].exp_drop));
      check($sformatf("tbl%0d_amt", i), HostFiFoFillAmt, vecs[i].exp_amt);
    end

    // F=300: 18 high / 46 low per 64-cycle period.
    frame(32'd300, -1, -1, 6, 1'b0);
    samp[0] = last_stall;
    for (int k = 1; k < 128; k++) begin idle(1); samp[k] = last_stall; end
    win0 = 0; win1 = 0;
    for (int k = 0; k < 64; k++) begin win0 += int'(samp[k]); win1 += int'(samp[k + 64]); end
    check("thr300_win0", 32'(win0), 32'd18);
    check("thr300_win1", 32'(win1), 32'd18);
    check("thr300_k17", 32'(samp[17]), 32'd1);
    check("thr300_k18", 32'(samp[18]), 32'd0);

    // F=800 with trailing beats, then HOLD overridden by F=100.
    a0 = acc_seen;
    frame(32'd800, -1, -1, 8, 1'b0);
    check("hold_single_acc", 32'(acc_seen - a0), 32'd1);
    highs = 0;
    for (int k = 0; k < 100; k++) begin idle(1); highs += int'(last_stall); end
    check("hold_cont", 32'(highs), 32'd100);
    a0 = acc_seen;
    frame(32'd100, -1, -1, 6, 1'b0);
    check("off_acc", 32'(acc_seen - a0), 32'd1);
    check("off_stall_next", 32'(last_stall), 32'd0);
    check("off_amt", HostFiFoFillAmt, 32'd100);

    // Timeout: 50 unstalled cycles with 10 frozen in the middle -> drop at 60.
    st_cfg = 0;
    frame(32'd800, -1, -1, 6, 1'b0);
    highs = int'(last_stall);
    for (int j = 1; j <= 70; j++) begin
      st_cfg = (j >= 20 && j <= 29) ? 1 : 0;
      idle(1);
      highs += int'(last_stall);
      if (j == 59) check("tmo_j59_high", 32'(last_stall), 32'd1);
      if (j == 60) check("tmo_j60_low", 32'(last_stall), 32'd0);
    end
    check("tmo_total_high", 32'(highs), 32'd60);
    check("tmo_amt_kept", HostFiFoFillAmt, 32'd800);

    // Commit landing on the expiry edge keeps HOLD.
    st_cfg = 0;
    frame(32'd800, -1, -1, 6, 1'b0);
    for (int j = 1; j <= 54; j++) begin
      st_cfg = (j >= 20 && j <= 29) ? 1 : 0;
      idle(1);
    end
    st_cfg = 0;
    frame(32'd900, -1, -1, 6, 1'b0);
    check("tmo_collide_stall", 32'(last_stall), 32'd1);
    idle(5);
    check("tmo_collide_hold", 32'(last_stall), 32'd1);
    check("tmo_collide_amt", HostFiFoFillAmt, 32'd900);

    // Reset mid-frame at w3; residual beats drop, next frame accepted.
    st_cfg = 1;
    step(1'b1, hdr(0), 4'hF, 1'b0);
    step(1'b1, hdr(1), 4'hF, 1'b0);
    step(1'b1, hdr(2), 4'hF, 1'b0);
    do_reset(1'b1, hdr(3));
    d0 = drop_seen;
    step(1'b1, hdr(4), 4'hF, 1'b0);
    step(1'b1, 32'd500, 4'hF, 1'b1);
    check("rst_residual_drop", 32'(drop_seen - d0), 32'd1);
    a0 = acc_seen;
    frame(32'd500, -1, -1, 6, 1'b0);
    check("rst_next_acc", 32'(acc_seen - a0), 32'd1);
    highs = int'(last_stall);
    for (int k = 1; k < 64; k++) begin idle(1); highs += int'(last_stall); end
    check("rst_thr500", 32'(highs), 32'd31);

    // Randomized frames against the model.
    st_cfg = 2;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 6))
        0: f = 32'd256;
        1: f = 32'd257;
        2: f = 32'd767;
        3: f = 32'd768;
        4: f = $urandom;
        default: f = 32'($urandom_range(0, 1100));
      endcase
      case ($urandom_range(0, 9))
        6: frame(f, $urandom_range(0, 4), -1, $urandom_range(1, 8), 1'b1);
        7: frame(f, -1, -1, $urandom_range(1, 5), 1'b1);
        8: frame(f, -1, $urandom_range(0, 5), $urandom_range(6, 8), 1'b1);
        9: frame(f, 0, -1, $urandom_range(1, 4), 1'b1);
        default: frame(f, -1, -1, $urandom_range(6, 8), 1'b1);
      endcase
      idle($urandom_range(0, 20));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
